// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I execute-stage encodings
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I ALU
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:  Result = A + B;
      ALU_SUB:  Result = A - B;
      ALU_AND:  Result = A & B;
      ALU_OR:   Result = A | B;
      ALU_XOR:  Result = A ^ B;
      ALU_SLT:  Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
      // only the low five bits of B form the shift amount
      ALU_SLL:  Result = A << B[4:0];
      default:  Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// rtl/execute_cycle.sv - EX stage: forwarding, ALU, branch resolve, EX/MEM register
module execute_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic [2:0]      ALUControlE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [REGW-1:0] RD_E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [REGW-1:0] RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            cond_true;

  // select 11 falls back to the register file value
  always_comb begin
    case (ForwardA_E)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .A          (src_a),
    .B          (src_b),
    .ALUControl (ALUControlE),
    .Result     (alu_result),
    .Zero       ()
  );

  // branch compare uses the forwarded operands, never the immediate
  always_comb begin
    cond_true = 1'b0;
    case (Funct3E)
      F3_BEQ:  cond_true = (src_a == fwd_b);
      F3_BNE:  cond_true = (src_a != fwd_b);
      F3_BLT:  cond_true = ($signed(src_a) < $signed(fwd_b));
      F3_BGE:  cond_true = !($signed(src_a) < $signed(fwd_b));
      F3_BLTU: cond_true = (src_a < fwd_b);
      F3_BGEU: cond_true = !(src_a < fwd_b);
      default: cond_true = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & cond_true);
  assign PCTargetE = PCE + Imm_Ext_E;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (FlushM) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (!StallM) begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= fwd_b;
      ALU_ResultM <= alu_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// tb/tb_execute_cycle.sv - randomized self-checking bench for execute_cycle
module tb_execute_cycle;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE;
  logic [2:0]      ALUControlE, Funct3E;
  logic [XLEN-1:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REGW-1:0] RD_E;
  logic [1:0]      ForwardA_E, ForwardB_E;
  logic            StallM, FlushM;
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            RegWriteM, MemWriteM, ResultSrcM;
  logic [REGW-1:0] RD_M;
  logic [XLEN-1:0] PCPlus4M, WriteDataM, ALU_ResultM;

  int n_vec  = 0;
  int n_miss = 0;

  // reference copy of the EX/MEM register contents
  logic            m_rw, m_mw, m_rs;
  logic [REGW-1:0] m_rd;
  logic [XLEN-1:0] m_pc4, m_wd, m_alu;

  execute_cycle #(.XLEN(XLEN), .REGW(REGW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ResultW(ResultW),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return a << sh;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ResultW;
    if (sel == 2'd2) return m_alu;
    return rf;
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic lt, ltu;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_m(input string tag);
    check_val({tag, "_regwrite"}, RegWriteM, m_rw);
    check_val({tag, "_memwrite"}, MemWriteM, m_mw);
    check_val({tag, "_resultsrc"}, ResultSrcM, m_rs);
    check_val({tag, "_rd"}, RD_M, m_rd);
    check_val({tag, "_pcplus4"}, PCPlus4M, m_pc4);
    check_val({tag, "_wdata"}, WriteDataM, m_wd);
    check_val({tag, "_alu"}, ALU_ResultM, m_alu);
  endtask

  task automatic zero_model();
    m_rw = 0; m_mw = 0; m_rs = 0; m_rd = '0;
    m_pc4 = '0; m_wd = '0; m_alu = '0;
  endtask

  // inputs are already applied; check combinational outputs, clock once, check registers
  task automatic step(input string tag);
    logic [31:0] a, b, sb, res;
    logic        exp_src;
    #1;
    a       = ref_fwd(ForwardA_E, RD1_E);
    b       = ref_fwd(ForwardB_E, RD2_E);
    sb      = ALUSrcE ? Imm_Ext_E : b;
    res     = ref_alu(ALUControlE, a, sb);
    exp_src = JumpE || (BranchE && ref_taken(Funct3E, a, b));
    check_val({tag, "_pcsrc"}, PCSrcE, exp_src);
    check_val({tag, "_pctarget"}, PCTargetE, PCE + Imm_Ext_E);
    @(posedge clk);
    if (FlushM) zero_model();
    else if (!StallM) begin
      m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RD_E;
      m_pc4 = PCPlus4E; m_wd = b; m_alu = res;
    end
    @(negedge clk);
    check_m(tag);
  endtask

  task automatic idle();
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0; BranchE = 0; JumpE = 0;
    ALUControlE = 3'd0; Funct3E = 3'd2; RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0;
    PCE = '0; PCPlus4E = '0; RD_E = '0; ResultW = '0;
    ForwardA_E = 2'd0; ForwardB_E = 2'd0; StallM = 0; FlushM = 0;
  endtask

  task automatic rand_e();
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
    ALUSrcE = 1'($urandom); BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
    ALUControlE = 3'($urandom); Funct3E = 3'($urandom);
    RD1_E = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
    RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
    Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = PCE + 4;
    RD_E = 5'($urandom); ResultW = $urandom;
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    zero_model();
    #2;
    check_m("reset");
    @(negedge clk);
    rst = 1'b1;

    // add with immediate
    RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 3'd0; RD_E = 3; RegWriteE = 1;
    step("add");
    check_val("add_const", ALU_ResultM, 32'd12);

    // forward from M and from W
    ForwardA_E = 2'd2; Imm_Ext_E = 1; ForwardB_E = 2'd1; ResultW = 32'hAA; MemWriteE = 1;
    step("chain");
    check_val("chain_alu", ALU_ResultM, 32'd13);
    check_val("chain_wd", WriteDataM, 32'hAA);

    // branches
    idle();
    BranchE = 1; Funct3E = 3'd4; RD1_E = 32'hFFFF_FFFF; RD2_E = 1; PCE = 32'h100; Imm_Ext_E = 32'h20;
    step("blt");
    check_val("blt_taken", PCSrcE, 1'b1);
    check_val("blt_target", PCTargetE, 32'h120);
    Funct3E = 3'd6;
    step("bltu");
    check_val("bltu_taken", PCSrcE, 1'b0);
    JumpE = 1;
    step("jal");
    check_val("jal_taken", PCSrcE, 1'b1);

    // stall holds, then flush beats stall
    idle();
    RD1_E = 9; RD2_E = 4; ALUControlE = 3'd1; RD_E = 7; RegWriteE = 1; ResultSrcE = 1; PCPlus4E = 32'h44;
    step("pre_stall");
    for (int i = 0; i < 2; i++) begin
      rand_e(); StallM = 1; FlushM = 0;
      step("stall");
    end
    check_val("stall_alu", ALU_ResultM, 32'd5);
    rand_e(); StallM = 1; FlushM = 1;
    step("flush");
    check_val("flush_rd", RD_M, 5'd0);
    check_val("flush_rw", RegWriteM, 1'b0);

    // async reset right after a capture
    idle();
    RD1_E = 32'h1234; RD2_E = 32'h55; RD_E = 9; RegWriteE = 1; MemWriteE = 1; PCPlus4E = 32'h8;
    step("pre_rst");
    #1 rst = 1'b0;
    #1;
    zero_model();
    check_m("async_rst");
    #1 rst = 1'b1;
    step("post_rst");

    // ALU corners
    idle();
    RD1_E = 0; RD2_E = 1; ALUControlE = 3'd1;
    step("sub");
    check_val("sub_const", ALU_ResultM, 32'hFFFF_FFFF);
    RD1_E = 32'hFFFF_FFFF; ALUControlE = 3'd5;
    step("slt");
    check_val("slt_const", ALU_ResultM, 32'd1);
    ALUControlE = 3'd6;
    step("sltu");
    check_val("sltu_const", ALU_ResultM, 32'd0);
    RD1_E = 1; RD2_E = 33; ALUControlE = 3'd7;
    step("sll");
    check_val("sll_const", ALU_ResultM, 32'd2);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      rand_e();
      StallM = ($urandom_range(0, 5) == 0);
      FlushM = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
